// File: rtl/rv32_pkg.sv
// Purpose: shared constants and types for the RV32 memory stage (access encodings, funct3 codes, FSM states).
// Latency: n/a (declarations only).
// Backpressure: n/a.
package rv32_pkg;

    // data_ctrl encoding from the EX/MEM register; bit 1 marks a memory access
    localparam logic [1:0] DCTRL_LOAD  = 2'b10;
    localparam logic [1:0] DCTRL_STORE = 2'b11;

    // Load/store funct3 codes
    localparam logic [2:0] F3_LB  = 3'b000;
    localparam logic [2:0] F3_LH  = 3'b001;
    localparam logic [2:0] F3_LW  = 3'b010;
    localparam logic [2:0] F3_LBU = 3'b100;
    localparam logic [2:0] F3_LHU = 3'b101;

    // funct3[1:0] size field, shared by loads and stores (SB/SH/SW use 000/001/010)
    localparam logic [1:0] SZ_BYTE = 2'b00;
    localparam logic [1:0] SZ_HALF = 2'b01;
    localparam logic [1:0] SZ_WORD = 2'b10;

    typedef enum logic [1:0] {
        ST_IDLE = 2'd0,
        ST_REQ  = 2'd1,
        ST_WAIT = 2'd2
    } mem_state_t;

    // Halfwords need addr[0] clear, words need addr[1:0] clear; bytes are always aligned
    function automatic logic is_misaligned(input logic [2:0] f3, input logic [1:0] off);
        logic mis;
        mis = 1'b0;
        case (f3[1:0])
            SZ_HALF: mis = off[0];
            SZ_WORD: mis = |off;
            default: mis = 1'b0;
        endcase
        return mis;
    endfunction

endpackage

// File: rtl/rv32_lsu_align.sv
// Purpose: byte-lane steering for stores and alignment/extension for loads.
// Latency: purely combinational, zero cycles.
// Backpressure: none; no state.
// Ports: funct3/addr_lo select size and lane; store_data -> be/wdata; rdata -> load_data.
module rv32_lsu_align
    import rv32_pkg::*;
(
    input  logic [2:0]  funct3,
    input  logic [1:0]  addr_lo,
    input  logic [31:0] store_data,
    input  logic [31:0] rdata,
    output logic [3:0]  be,
    output logic [31:0] wdata,
    output logic [31:0] load_data
);

    logic [7:0]  byte_sel;
    logic [15:0] half_sel;
    logic        sign_ext;

    // Store side: data is replicated across lanes so the byte enables alone pick the target
    always_comb begin
        be    = 4'b1111;
        wdata = store_data;
        case (funct3[1:0])
            SZ_BYTE: begin
                be    = 4'b0001 << addr_lo;
                wdata = {4{store_data[7:0]}};
            end
            SZ_HALF: begin
                be    = 4'b0011 << {addr_lo[1], 1'b0};
                wdata = {2{store_data[15:0]}};
            end
            default: ;
        endcase
    end

    // Load side: funct3[2] set means unsigned (LBU/LHU)
    always_comb begin
        byte_sel  = 8'(rdata >> {addr_lo, 3'b000});
        half_sel  = 16'(rdata >> {addr_lo[1], 4'b0000});
        sign_ext  = ~funct3[2];
        load_data = rdata;
        case (funct3)
            F3_LB, F3_LBU: load_data = {{24{byte_sel[7] & sign_ext}}, byte_sel};
            F3_LH, F3_LHU: load_data = {{16{half_sel[15] & sign_ext}}, half_sel};
            F3_LW:         load_data = rdata;
            default:       load_data = rdata;
        endcase
    end

endmodule

// File: rtl/rv32_mem_stage.sv
// Purpose: RV32 MEM stage: issues data-memory requests, formats loads, flags misaligned accesses.
// Latency: request is combinational in the access cycle; load data appears combinationally with rvalid.
// Backpressure: mem_stall holds upstream until gnt (store) or rvalid (load); misaligned/halted never stall.
// Ports: EX/MEM inputs (alu_res_in, data_store_in, data_ctrl_in, code_in, pc_hlt_in);
//        dmem_* request/response handshake; load_data_out, mem_stall, misalign_out to MEM/WB and hazard logic.
module rv32_mem_stage
    import rv32_pkg::*;
(
    input  logic        clk,
    input  logic        rst_n,
    input  logic [31:0] alu_res_in,
    input  logic [31:0] data_store_in,
    input  logic [1:0]  data_ctrl_in,
    input  logic [31:0] code_in,
    input  logic        pc_hlt_in,
    output logic        dmem_req,
    output logic        dmem_we,
    output logic [31:0] dmem_addr,
    output logic [3:0]  dmem_be,
    output logic [31:0] dmem_wdata,
    input  logic        dmem_gnt,
    input  logic        dmem_rvalid,
    input  logic [31:0] dmem_rdata,
    output logic [31:0] load_data_out,
    output logic        mem_stall,
    output logic        misalign_out
);

    mem_state_t  state, state_nxt;

    logic [2:0]  funct3;
    logic        access_vld;
    logic        is_store;
    logic        misaligned;
    logic        in_idle;

    // Request snapshot taken while in IDLE, replayed while waiting on gnt/rvalid
    logic [31:2] req_addr;
    logic        req_we;
    logic [3:0]  req_be;
    logic [31:0] req_wdata;
    logic [2:0]  req_f3;
    logic [1:0]  req_off;

    logic [31:0] load_hold;
    logic        req_int, stall_int, mis_int, rsp_take;

    logic [2:0]  al_f3;
    logic [1:0]  al_off;
    logic [3:0]  al_be;
    logic [31:0] al_wdata;
    logic [31:0] al_load;

    logic        unused_code;
    assign unused_code = ^{code_in[31:15], code_in[11:0]};

    assign funct3     = code_in[14:12];
    assign access_vld = data_ctrl_in[1] & ~pc_hlt_in;
    assign is_store   = (data_ctrl_in == DCTRL_STORE);
    assign misaligned = is_misaligned(funct3, alu_res_in[1:0]);
    assign in_idle    = (state == ST_IDLE);

    // Outside IDLE the live inputs may not describe the access in flight, so use the snapshot
    assign al_f3  = in_idle ? funct3 : req_f3;
    assign al_off = in_idle ? alu_res_in[1:0] : req_off;

    rv32_lsu_align u_align (
        .funct3     (al_f3),
        .addr_lo    (al_off),
        .store_data (data_store_in),
        .rdata      (dmem_rdata),
        .be         (al_be),
        .wdata      (al_wdata),
        .load_data  (al_load)
    );

    always_comb begin
        state_nxt = state;
        req_int   = 1'b0;
        stall_int = 1'b0;
        mis_int   = 1'b0;
        rsp_take  = 1'b0;
        case (state)
            ST_IDLE: begin
                if (access_vld) begin
                    if (misaligned) begin
                        mis_int = 1'b1;
                    end else begin
                        req_int = 1'b1;
                        if (dmem_gnt) begin
                            if (!is_store) begin
                                state_nxt = ST_WAIT;
                                stall_int = 1'b1;
                            end
                        end else begin
                            state_nxt = ST_REQ;
                            stall_int = 1'b1;
                        end
                    end
                end
            end
            ST_REQ: begin
                req_int   = 1'b1;
                stall_int = 1'b1;
                if (dmem_gnt) begin
                    if (req_we) begin
                        state_nxt = ST_IDLE;
                        stall_int = 1'b0;
                    end else begin
                        state_nxt = ST_WAIT;
                    end
                end
            end
            ST_WAIT: begin
                stall_int = 1'b1;
                if (dmem_rvalid) begin
                    state_nxt = ST_IDLE;
                    stall_int = 1'b0;
                    rsp_take  = 1'b1;
                end
            end
            default: state_nxt = ST_IDLE;
        endcase
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state     <= ST_IDLE;
            load_hold <= 32'd0;
            req_addr  <= 30'd0;
            req_we    <= 1'b0;
            req_be    <= 4'd0;
            req_wdata <= 32'd0;
            req_f3    <= 3'd0;
            req_off   <= 2'd0;
        end else begin
            state <= state_nxt;
            if (in_idle) begin
                req_addr  <= alu_res_in[31:2];
                req_we    <= is_store;
                req_be    <= al_be;
                req_wdata <= al_wdata;
                req_f3    <= funct3;
                req_off   <= alu_res_in[1:0];
            end
            if (rsp_take) begin
                load_hold <= al_load;
            end
        end
    end

    // Combinational outputs are qualified by rst_n: state is already IDLE during reset,
    // but live EX/MEM inputs could otherwise still raise a request.
    assign dmem_req      = req_int & rst_n;
    assign dmem_we       = dmem_req & (in_idle ? is_store : req_we);
    assign dmem_be       = dmem_req ? (in_idle ? al_be : req_be) : 4'd0;
    assign dmem_wdata    = in_idle ? al_wdata : req_wdata;
    assign dmem_addr     = in_idle ? {alu_res_in[31:2], 2'b00} : {req_addr, 2'b00};
    assign mem_stall     = stall_int & rst_n;
    assign misalign_out  = mis_int & rst_n;
    assign load_data_out = rsp_take ? al_load : load_hold;

endmodule
